// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA bouncing-ball motion controller.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;
  localparam int RADIUS_DEF   = 100;

  localparam int POS_W   = 10;
  localparam int SPEED_W = 4;
  localparam int DIV_W   = 8;
  localparam int BCNT_W  = 8;

  // Ball centre after reset: middle of the 640x480 visible area.
  localparam logic [POS_W-1:0] RST_X = 10'd320;
  localparam logic [POS_W-1:0] RST_Y = 10'd240;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC_X = 2'd1,
    CALC_Y = 2'd2,
    COMMIT = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/axis_bounce_step.sv
// One-axis position step with reflection at the [min, max] bounds.
// Purely combinational; the controller instantiates one per axis.
module axis_bounce_step
  import vga_pkg::*;
(
  input  logic [POS_W-1:0]   pos,
  input  logic               dir,
  input  logic [SPEED_W-1:0] step,
  input  logic [POS_W-1:0]   min,
  input  logic [POS_W-1:0]   max,
  output logic [POS_W-1:0]   next_pos,
  output logic               next_dir,
  output logic               bounced
);

  // One bit of headroom so pos+step near the top of the range cannot wrap.
  logic [POS_W:0] fwd;
  logic [POS_W:0] bwd;
  logic [POS_W:0] min_w;
  logic [POS_W:0] max_w;

  assign fwd   = {1'b0, pos} + {{(POS_W + 1 - SPEED_W){1'b0}}, step};
  assign bwd   = {1'b0, pos} - {{(POS_W + 1 - SPEED_W){1'b0}}, step};
  assign min_w = {1'b0, min};
  assign max_w = {1'b0, max};

  // Advance toward the current direction; landing on or past a bound clamps and reverses.
  // A zero step is a pure hold, even when parked on a bound.
  always_comb begin
    next_pos = pos;
    next_dir = dir;
    bounced  = 1'b0;
    if (step != '0) begin
      if (dir) begin
        if (fwd >= max_w) begin
          next_pos = max;
          next_dir = 1'b0;
          bounced  = 1'b1;
        end else begin
          next_pos = fwd[POS_W-1:0];
        end
      end else begin
        if (bwd <= min_w) begin
          next_pos = min;
          next_dir = 1'b1;
          bounced  = 1'b1;
        end else begin
          next_pos = bwd[POS_W-1:0];
        end
      end
    end
  end

endmodule

// File: rtl/ball_motion_ctrl.sv
// Frame-synchronous ball motion controller. A qualifying frame_tick launches a
// three-cycle IDLE->CALC_X->CALC_Y->COMMIT sequence; X and Y are computed into
// shadow registers and committed together so the renderer never sees a torn update.
// Optional feature macro: BALL_BOUNCE_CNT_EN adds the bounce_cnt output and counter.
module ball_motion_ctrl
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = H_ACTIVE_DEF,
  parameter int V_ACTIVE  = V_ACTIVE_DEF,
  parameter int RADIUS    = RADIUS_DEF,
  parameter int FRAME_DIV = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               frame_tick,
  input  logic               run_en,
  input  logic [SPEED_W-1:0] speed,
  output logic [POS_W-1:0]   ball_x,
  output logic [POS_W-1:0]   ball_y,
  output logic               dir_x,
  output logic               dir_y,
  output logic               pos_valid
`ifdef BALL_BOUNCE_CNT_EN
  ,
  output logic [BCNT_W-1:0]  bounce_cnt
`endif
);

  localparam logic [POS_W-1:0] X_MIN    = POS_W'(RADIUS);
  localparam logic [POS_W-1:0] X_MAX    = POS_W'(H_ACTIVE - 1 - RADIUS);
  localparam logic [POS_W-1:0] Y_MIN    = POS_W'(RADIUS);
  localparam logic [POS_W-1:0] Y_MAX    = POS_W'(V_ACTIVE - 1 - RADIUS);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(FRAME_DIV - 1);

  ctrl_state_t state_q;
  ctrl_state_t state_d;

  logic [DIV_W-1:0]   divider_q;
  logic               tick_idle;
  logic               launch;

  logic [SPEED_W-1:0] speed_p0;
  logic [POS_W-1:0]   shadow_x_p1;
  logic               shadow_dx_p1;
  logic               bounce_x_p1;
  logic [POS_W-1:0]   shadow_y_p2;
  logic               shadow_dy_p2;
  logic               bounce_y_p2;

  logic [POS_W-1:0]   x_next;
  logic               x_dir_next;
  logic               x_bounced;
  logic [POS_W-1:0]   y_next;
  logic               y_dir_next;
  logic               y_bounced;

  // Ticks only count while idle; a tick that lands mid-sequence is dropped entirely.
  assign tick_idle = (state_q == IDLE) && frame_tick && run_en;
  assign launch    = tick_idle && (divider_q == DIV_LAST);

  axis_bounce_step u_step_x (
    .pos      (ball_x),
    .dir      (dir_x),
    .step     (speed_p0),
    .min      (X_MIN),
    .max      (X_MAX),
    .next_pos (x_next),
    .next_dir (x_dir_next),
    .bounced  (x_bounced)
  );

  axis_bounce_step u_step_y (
    .pos      (ball_y),
    .dir      (dir_y),
    .step     (speed_p0),
    .min      (Y_MIN),
    .max      (Y_MAX),
    .next_pos (y_next),
    .next_dir (y_dir_next),
    .bounced  (y_bounced)
  );

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: one cycle per computation state, launch only from IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (launch) state_d = CALC_X;
      CALC_X:  state_d = CALC_Y;
      CALC_Y:  state_d = COMMIT;
      COMMIT:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Frame divider: counts qualifying idle ticks, clears on the launching one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      divider_q <= '0;
    end else if (tick_idle) begin
      divider_q <= launch ? '0 : divider_q + 1'b1;
    end
  end

  // Datapath stages: speed capture at launch, X shadow in CALC_X, Y shadow in CALC_Y.
  always_ff @(posedge clk) begin
    // p0: step size frozen for the whole sequence
    if (launch) begin
      speed_p0 <= speed;
    end
    // p1: X axis result
    if (state_q == CALC_X) begin
      shadow_x_p1  <= x_next;
      shadow_dx_p1 <= x_dir_next;
      bounce_x_p1  <= x_bounced;
    end
    // p2: Y axis result
    if (state_q == CALC_Y) begin
      shadow_y_p2  <= y_next;
      shadow_dy_p2 <= y_dir_next;
      bounce_y_p2  <= y_bounced;
    end
  end

  // Committed position and directions change together; pos_valid marks the first visible cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ball_x    <= RST_X;
      ball_y    <= RST_Y;
      dir_x     <= 1'b1;
      dir_y     <= 1'b1;
      pos_valid <= 1'b0;
    end else begin
      pos_valid <= (state_q == COMMIT);
      if (state_q == COMMIT) begin
        ball_x <= shadow_x_p1;
        ball_y <= shadow_y_p2;
        dir_x  <= shadow_dx_p1;
        dir_y  <= shadow_dy_p2;
      end
    end
  end

`ifdef BALL_BOUNCE_CNT_EN
  // Bounce counter: one per axis bounce at commit, so a corner hit adds two; wraps naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bounce_cnt <= '0;
    end else if (state_q == COMMIT) begin
      bounce_cnt <= bounce_cnt + BCNT_W'(bounce_x_p1) + BCNT_W'(bounce_y_p2);
    end
  end
`else
  // Bounce flags have no consumer without the counter.
  logic bounce_unused;
  assign bounce_unused = bounce_x_p1 | bounce_y_p2;
`endif

endmodule
